// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - instruction prefetch queue with head-word field decode and halt/resume control
module instr_fetch_queue #(
    parameter int INSTR_W    = 32,
    parameter int OP_W       = 5,
    parameter int REG_W      = 5,
    parameter int IMM_W      = 14,
    parameter int TYPE_W     = 2,
    parameter int DEPTH      = 4,
    parameter int IMM_SIGNED = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [INSTR_W-1:0]         in_instr,
    input  logic                       flush,
    input  logic                       resume,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OP_W-1:0]            operation,
    output logic [REG_W-1:0]           src_1,
    output logic [REG_W-1:0]           dest,
    output logic [IMM_W-1:0]           immediate,
    output logic [TYPE_W-1:0]          instr_type,
    output logic                       halt_bit,
    output logic [INSTR_W-1:0]         imm_ext,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       halted
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic {ST_RUN, ST_HALTED} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [INSTR_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [INSTR_W-1:0] w_head;
    logic               w_push;
    logic               w_pop;

    // in_ready looks only at occupancy, so a full queue never accepts even while popping
    assign in_ready  = (r_count < FULL);
    assign out_valid = (r_count != '0) && (r_state == ST_RUN);
    assign w_push    = in_valid && in_ready && !flush;
    assign w_pop     = out_valid && out_ready && !flush;

    assign w_head     = r_mem[r_rd_ptr];
    assign operation  = w_head[INSTR_W-1 -: OP_W];
    assign src_1      = w_head[INSTR_W-OP_W-1 -: REG_W];
    assign dest       = w_head[INSTR_W-OP_W-REG_W-1 -: REG_W];
    assign immediate  = w_head[INSTR_W-OP_W-2*REG_W-1 -: IMM_W];
    assign instr_type = w_head[TYPE_W:1];
    assign halt_bit   = w_head[0];
    assign count      = r_count;
    assign halted     = (r_state == ST_HALTED);

    generate
        if (IMM_SIGNED != 0) begin : g_imm_sx
            assign imm_ext = {{(INSTR_W-IMM_W){immediate[IMM_W-1]}}, immediate};
        end else begin : g_imm_zx
            assign imm_ext = {{(INSTR_W-IMM_W){1'b0}}, immediate};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_instr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The halting word is itself issued; the stop takes effect on the following cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_pop && halt_bit) begin
                    w_state_nxt = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (resume) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - scoreboard bench for instr_fetch_queue with random and directed traffic
module tb_instr_fetch_queue;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic        flush = 1'b0;
    logic        resume = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, halt_bit, halted;
    logic [4:0]  operation, src_1, dest;
    logic [13:0] immediate;
    logic [1:0]  instr_type;
    logic [31:0] imm_ext;
    logic [2:0]  count;

    logic        z_in_ready, z_out_valid, z_halt_bit, z_halted;
    logic [4:0]  z_operation, z_src_1, z_dest;
    logic [13:0] z_immediate;
    logic [1:0]  z_instr_type;
    logic [31:0] z_imm_ext;
    logic [2:0]  z_count;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];
    bit          exp_halted = 1'b0;

    always #5 clk = ~clk;

    instr_fetch_queue #(.IMM_SIGNED(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .flush(flush), .resume(resume), .out_valid(out_valid),
        .out_ready(out_ready), .operation(operation), .src_1(src_1), .dest(dest),
        .immediate(immediate), .instr_type(instr_type), .halt_bit(halt_bit),
        .imm_ext(imm_ext), .count(count), .halted(halted)
    );

    instr_fetch_queue #(.IMM_SIGNED(0)) u_dut_zx (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(z_in_ready),
        .in_instr(in_instr), .flush(flush), .resume(resume), .out_valid(z_out_valid),
        .out_ready(out_ready), .operation(z_operation), .src_1(z_src_1), .dest(z_dest),
        .immediate(z_immediate), .instr_type(z_instr_type), .halt_bit(z_halt_bit),
        .imm_ext(z_imm_ext), .count(z_count), .halted(z_halted)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor / reference model: checks outputs mid-cycle, then advances the queue model
    always @(negedge clk) begin
        logic [31:0] w;
        logic [31:0] imm;
        bit          ev, pop, push, nh;
        if (rst_n) begin
            ev = (exp_q.size() > 0) && !exp_halted;
            chk("count", 32'(count), exp_q.size());
            chk("in_ready", 32'(in_ready), 32'(exp_q.size() < 4));
            chk("out_valid", 32'(out_valid), 32'(ev));
            chk("halted", 32'(halted), 32'(exp_halted));
            chk("zx_count", 32'(z_count), exp_q.size());
            w = '0;
            if (exp_q.size() > 0) begin
                w = exp_q[0];
            end
            if (ev) begin
                imm = (w >> 3) & 32'h3FFF;
                chk("operation", 32'(operation), w >> 27);
                chk("src_1", 32'(src_1), (w >> 22) & 32'h1F);
                chk("dest", 32'(dest), (w >> 17) & 32'h1F);
                chk("immediate", 32'(immediate), imm);
                chk("instr_type", 32'(instr_type), (w >> 1) & 32'h3);
                chk("halt_bit", 32'(halt_bit), w & 32'h1);
                chk("imm_ext_sx", imm_ext, (imm >= 32'h2000) ? (imm | 32'hFFFF_C000) : imm);
                chk("imm_ext_zx", z_imm_ext, imm);
            end
            pop  = ev && out_ready;
            push = in_valid && (exp_q.size() < 4);
            nh   = exp_halted;
            if (exp_halted && resume) begin
                nh = 1'b0;
            end else if (!exp_halted && pop && !flush && (w % 2 == 1)) begin
                nh = 1'b1;
            end
            if (flush) begin
                exp_q.delete();
            end else begin
                if (pop) void'(exp_q.pop_front());
                if (push) exp_q.push_back(in_instr);
            end
            exp_halted = nh;
        end
    end

    task automatic drive(bit v, logic [31:0] d, bit rdy, bit fl, bit rs);
        in_valid  = v;
        in_instr  = d;
        out_ready = rdy;
        flush     = fl;
        resume    = rs;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_word(bit halt);
        logic [31:0] t;
        t    = $urandom;
        t[0] = halt;
        return t;
    endfunction

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_halted", 32'(halted), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Fill to full with no pops
        drive(1, 32'h0840_0018, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(1, rnd_word(0), 0, 0, 0);
        chk("fill_count", 32'(count), 4);
        chk("fill_in_ready", 32'(in_ready), 0);
        chk("fill_op", 32'(operation), 1);
        chk("fill_src", 32'(src_1), 1);
        chk("fill_dest", 32'(dest), 0);
        chk("fill_imm", 32'(immediate), 3);
        chk("fill_type", 32'(instr_type), 0);
        chk("fill_halt", 32'(halt_bit), 0);
        drive(1, rnd_word(0), 1, 0, 0);
        chk("full_push_pop_count", 32'(count), 3);
        drive(0, '0, 0, 1, 0);
        chk("flush_count", 32'(count), 0);

        // Streaming across pointer wrap
        for (int i = 0; i < 20; i++) begin
            drive(1, rnd_word(0), 1, 0, 0);
            chk("stream_count", 32'(count), 1);
        end
        drive(0, '0, 1, 0, 0);
        chk("drain_count", 32'(count), 0);

        // Halt, prefetch while halted, resume
        drive(1, rnd_word(0), 0, 0, 0);
        drive(1, rnd_word(1), 0, 0, 0);
        drive(1, rnd_word(0), 0, 0, 0);
        drive(0, '0, 1, 0, 0);
        drive(0, '0, 1, 0, 0);
        chk("halt_out_valid", 32'(out_valid), 0);
        chk("halt_halted", 32'(halted), 1);
        chk("halt_count", 32'(count), 1);
        drive(1, rnd_word(1), 1, 0, 0);
        chk("halt_push_count", 32'(count), 2);
        drive(0, '0, 0, 0, 1);
        chk("resume_out_valid", 32'(out_valid), 1);
        chk("resume_halted", 32'(halted), 0);
        drive(0, '0, 1, 0, 0);
        drive(0, '0, 1, 0, 0);
        chk("halt2_halted", 32'(halted), 1);
        drive(1, rnd_word(0), 0, 0, 0);
        drive(1, rnd_word(0), 0, 0, 0);
        chk("pre_rst_count", 32'(count), 2);
        chk("pre_rst_halted", 32'(halted), 1);

        // Asynchronous reset between clock edges
        in_valid = 1'b0;
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_halted", 32'(halted), 0);
        chk("arst_in_ready", 32'(in_ready), 1);
        chk("arst_out_valid", 32'(out_valid), 0);
        exp_q.delete();
        exp_halted = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Immediate extension on both variants
        drive(1, 32'h0001_0000, 0, 0, 0);
        chk("sx_imm_ext", imm_ext, 32'hFFFF_E000);
        chk("zx_imm_ext", z_imm_ext, 32'h0000_2000);
        drive(0, '0, 1, 0, 0);

        // Flush colliding with push and pop
        for (int i = 0; i < 3; i++) drive(1, rnd_word(0), 0, 0, 0);
        chk("coll_pre_count", 32'(count), 3);
        drive(1, rnd_word(0), 1, 1, 0);
        chk("coll_count", 32'(count), 0);
        chk("coll_out_valid", 32'(out_valid), 0);
        drive(0, '0, 0, 0, 0);
        chk("coll_lost_count", 32'(count), 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 9) < 7, rnd_word($urandom_range(0, 7) == 0),
                  $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 4) == 0);
        end
        drive(0, '0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
